snoop_dispatch: RTL and testbench

Snooper-side counterpart of the forwarder arbiter. Hands each incoming packet from the single snooper to one of N packetfilter_cores that advertise readiness, using rotating (round-robin) priority. Gates the snooper's hot write/done strobes to the granted core only. Sits between the snooper and the core array inside parallel_cores.

---
 rtl/snoop_dispatch_pkg.sv | 15 +
 rtl/snoop_dispatch_rr_pick.sv | 29 ++
 rtl/snoop_dispatch.sv | 134 +++++++++++++
 tb/tb_snoop_dispatch.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_dispatch_pkg.sv
// Shared types and helpers for the snooper-side dispatcher and its round-robin picker.
package snoop_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } sd_state_t;

  // Index width for N cores; a single core still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snoop_dispatch_rr_pick.sv
// rr_pick: combinational rotate-priority encoder; searches req starting at ptr+1 (mod N).
module rr_pick
  import snoop_dispatch_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] w_j;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    w_j = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_j = IW'((32'(ptr) + k) % N);
      if (!hit && req[w_j]) begin
        hit = 1'b1;
        idx = w_j;
      end
    end
  end

endmodule

// File: rtl/snoop_dispatch.sv
// snoop_dispatch: round-robin hand-off of snooper packets to N ready cores.
// Optional statistics counters enabled by defining SNOOP_DISPATCH_STATS_EN.
module snoop_dispatch
  import snoop_dispatch_pkg::*;
#(
  parameter int unsigned N                  = 4,
  parameter int unsigned PACKMEM_ADDR_WIDTH = 8,
  parameter int unsigned PACKMEM_DATA_WIDTH = 64,
  parameter int unsigned INC_WIDTH          = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PACKMEM_ADDR_WIDTH-1:0] addr,
  input  logic [PACKMEM_DATA_WIDTH-1:0] wr_data,
  input  logic                          wr_en,
  input  logic [INC_WIDTH-1:0]          byte_inc,
  input  logic                          done,
  output logic                          rdy,
  input  logic                          ack,
  output logic [PACKMEM_ADDR_WIDTH-1:0] sn_addr,
  output logic [PACKMEM_DATA_WIDTH-1:0] sn_wr_data,
  output logic [INC_WIDTH-1:0]          sn_byte_inc,
  output logic [N-1:0]                  sn_wr_en,
  output logic [N-1:0]                  sn_done,
  input  logic [N-1:0]                  rdy_for_sn,
  output logic [N-1:0]                  rdy_for_sn_ack
`ifdef SNOOP_DISPATCH_STATS_EN
  ,
  output logic [31:0]                   pkt_cnt,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int unsigned IW = idx_width(N);

  sd_state_t     r_state, w_state_next;
  logic [IW-1:0] r_cand, r_sel, r_ptr;
  logic [N-1:0]  r_ack;
  logic [IW-1:0] w_pick_idx;
  logic          w_pick_hit;
  logic          w_take, w_grant;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (rdy_for_sn),
    .ptr (r_ptr),
    .hit (w_pick_hit),
    .idx (w_pick_idx)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_grant      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_hit) begin
          w_state_next = OFFER;
          w_take       = 1'b1;
        end
      end
      OFFER: begin
        if (ack) begin
          w_state_next = BUSY;
          w_grant      = 1'b1;
        end else if (!rdy_for_sn[r_cand]) begin
          w_state_next = IDLE;
        end
      end
      BUSY: begin
        if (done) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ptr resets to N-1 so the first search after reset begins at core 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cand <= '0;
      r_sel  <= '0;
      r_ptr  <= IW'(N - 1);
      r_ack  <= '0;
    end else begin
      r_ack <= '0;
      if (w_take) r_cand <= w_pick_idx;
      if (w_grant) begin
        r_sel         <= r_cand;
        r_ptr         <= r_cand;
        r_ack[r_cand] <= 1'b1;
      end
    end
  end

  assign rdy            = (r_state == OFFER);
  assign rdy_for_sn_ack = r_ack;
  assign sn_addr        = addr;
  assign sn_wr_data     = wr_data;
  assign sn_byte_inc    = byte_inc;

  always_comb begin
    sn_wr_en = '0;
    sn_done  = '0;
    if (r_state == BUSY) begin
      sn_wr_en[r_sel] = wr_en;
      sn_done[r_sel]  = done;
    end
  end

`ifdef SNOOP_DISPATCH_STATS_EN
  logic [31:0] r_pkt_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pkt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (r_state == BUSY && done && r_pkt_cnt != '1)
        r_pkt_cnt <= r_pkt_cnt + 32'd1;
      if (r_state != BUSY && wr_en && r_drop_cnt != '1)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign pkt_cnt  = r_pkt_cnt;
  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_snoop_dispatch.sv
// Self-checking bench for snoop_dispatch (N=4) against an ownership/offer reference model.
module tb_snoop_dispatch;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 64;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_en = 1'b0;
  logic [BW-1:0] byte_inc = '0;
  logic          done = 1'b0;
  logic          ack = 1'b0;
  logic [N-1:0]  rdy_for_sn = '0;
  logic          rdy;
  logic [AW-1:0] sn_addr;
  logic [DW-1:0] sn_wr_data;
  logic [BW-1:0] sn_byte_inc;
  logic [N-1:0]  sn_wr_en, sn_done, rdy_for_sn_ack;
`ifdef SNOOP_DISPATCH_STATS_EN
  logic [31:0]   pkt_cnt;
  logic [15:0]   drop_cnt;
`endif

  snoop_dispatch #(
    .N(N), .PACKMEM_ADDR_WIDTH(AW), .PACKMEM_DATA_WIDTH(DW), .INC_WIDTH(BW)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr_data(wr_data), .wr_en(wr_en),
    .byte_inc(byte_inc), .done(done), .rdy(rdy), .ack(ack),
    .sn_addr(sn_addr), .sn_wr_data(sn_wr_data), .sn_byte_inc(sn_byte_inc),
    .sn_wr_en(sn_wr_en), .sn_done(sn_done), .rdy_for_sn(rdy_for_sn),
    .rdy_for_sn_ack(rdy_for_sn_ack)
`ifdef SNOOP_DISPATCH_STATS_EN
    , .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: which core is being offered, which core owns the stream,
  // who was granted last, and the ack pulse expected this cycle.
  int           m_offer = -1;
  int           m_owner = -1;
  int           m_last  = N - 1;
  logic [N-1:0] m_ack   = '0;
  longint       m_pkt   = 0;
  longint       m_drop  = 0;
  int           grants[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_offer = -1; m_owner = -1; m_last = N - 1; m_ack = '0; m_pkt = 0; m_drop = 0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_we, e_dn;
    e_we = '0; e_dn = '0;
    if (m_owner >= 0) begin
      if (wr_en) e_we = N'(1) << m_owner;
      if (done)  e_dn = N'(1) << m_owner;
    end
    chk("rdy", 64'(rdy), 64'(m_offer >= 0));
    chk("ack_pulse", 64'(rdy_for_sn_ack), 64'(m_ack));
    chk("sn_wr_en", 64'(sn_wr_en), 64'(e_we));
    chk("sn_done", 64'(sn_done), 64'(e_dn));
    chk("sn_addr", 64'(sn_addr), 64'(addr));
    chk("sn_wr_data", sn_wr_data, wr_data);
    chk("sn_byte_inc", 64'(sn_byte_inc), 64'(byte_inc));
`ifdef SNOOP_DISPATCH_STATS_EN
    chk("pkt_cnt", 64'(pkt_cnt), 64'(m_pkt));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`endif
    for (int k = 0; k < N; k++)
      if (rdy_for_sn_ack[k]) grants.push_back(k);
  endtask

  task automatic model_edge();
    logic [N-1:0] nack;
    nack = '0;
    if (!rst) begin
      model_reset();
      return;
    end
    if (wr_en && m_owner < 0 && m_drop < 64'hFFFF) m_drop++;
    if (m_owner >= 0) begin
      if (done) begin
        m_owner = -1;
        if (m_pkt < 64'hFFFF_FFFF) m_pkt++;
      end
    end else if (m_offer >= 0) begin
      if (ack) begin
        nack[m_offer] = 1'b1;
        m_owner = m_offer; m_last = m_offer; m_offer = -1;
      end else if (!rdy_for_sn[m_offer]) begin
        m_offer = -1;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (rdy_for_sn[j]) begin
          m_offer = j;
          break;
        end
      end
    end
    m_ack = nack;
  endtask

  task automatic tick();
    #4;
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; ack = 1'b0; wr_en = 1'b0; done = 1'b0; rdy_for_sn = '0;
    model_reset();
    #1;
    check_outputs();
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic wait_offer(input string tag);
    for (int t = 0; t < 10 && m_offer < 0; t++) tick();
    if (m_offer < 0) chk(tag, 64'd0, 64'd1);
  endtask

  task automatic one_packet(input int nwr);
    wait_offer("offer_timeout");
    ack = 1'b1; tick(); ack = 1'b0;
    for (int w = 0; w < nwr; w++) begin
      wr_en = 1'b1; addr = AW'(w); wr_data = {$urandom, $urandom}; byte_inc = BW'($urandom);
      tick();
    end
    wr_en = 1'b0; done = 1'b1; tick(); done = 1'b0;
  endtask

  initial begin
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};

    do_reset();
    chk("reset_rdy", 64'(rdy), 64'd0);
    chk("reset_ack", 64'(rdy_for_sn_ack), 64'd0);

    // Single packet to core 2.
    rdy_for_sn = 4'b0100;
    tick();
    chk("rdy_rise", 64'(rdy), 64'd1);
    ack = 1'b1; tick(); ack = 1'b0; rdy_for_sn = '0;
    chk("grant_core2", 64'(rdy_for_sn_ack), 64'h4);
    chk("rdy_drop", 64'(rdy), 64'd0);
    for (int a = 0; a < 4; a++) begin
      addr = AW'(a); wr_data = {$urandom, $urandom}; wr_en = 1'b1; tick();
      wr_en = 1'b0; tick();
    end
    done = 1'b1; #1;
    chk("done_core2", 64'(sn_done), 64'h4);
    tick(); done = 1'b0;
    tick();
    chk("no_early_rdy", 64'(rdy), 64'd0);

    // Rotation with every core ready.
    do_reset();
    grants.delete();
    rdy_for_sn = 4'b1111;
    for (int p = 0; p < 5; p++) one_packet(2);
    rdy_for_sn = '0;
    chk("grant_count", 64'(grants.size()), 64'd5);
    for (int p = 0; p < 5 && p < grants.size(); p++) chk("grant_order", 64'(grants[p]), 64'(exp_order[p]));

    // Offered core withdraws before ack.
    tick(); tick();
    rdy_for_sn = 4'b0010;
    tick(); tick();
    chk("offer_core1", 64'(rdy), 64'd1);
    rdy_for_sn = 4'b0000;
    tick();
    chk("withdraw_rdy", 64'(rdy), 64'd0);
    chk("withdraw_noack", 64'(rdy_for_sn_ack), 64'd0);
    rdy_for_sn = 4'b0010;
    tick(); tick();
    chk("reoffer", 64'(rdy), 64'd1);
    rdy_for_sn = '0; tick(); tick();

    // Strobes while idle are dropped.
    do_reset();
    wr_en = 1'b1; done = 1'b1; tick();
    wr_en = 1'b0; done = 1'b0;
    chk("idle_rdy", 64'(rdy), 64'd0);
`ifdef SNOOP_DISPATCH_STATS_EN
    chk("idle_drop_cnt", 64'(drop_cnt), 64'd1);
    chk("idle_pkt_cnt", 64'(pkt_cnt), 64'd0);
`endif

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      rdy_for_sn = N'($urandom);
      ack        = 1'($urandom_range(0, 1));
      wr_en      = 1'($urandom_range(0, 1));
      done       = ($urandom_range(0, 3) == 0);
      addr       = AW'($urandom);
      wr_data    = {$urandom, $urandom};
      byte_inc   = BW'($urandom);
      tick();
    end
    ack = 1'b0; wr_en = 1'b0; done = 1'b0;

    // Reset in the middle of a packet.
    do_reset();
    rdy_for_sn = 4'b1000;
    wait_offer("offer_timeout_mid");
    ack = 1'b1; tick(); ack = 1'b0; rdy_for_sn = '0;
    for (int w = 0; w < 3; w++) begin
      wr_en = 1'b1; addr = AW'(w); tick();
    end
    chk("busy_we", 64'(sn_wr_en), 64'h8);
    rst = 1'b0; model_reset(); #1;
    chk("async_we", 64'(sn_wr_en), 64'd0);
    chk("async_rdy", 64'(rdy), 64'd0);
    done = 1'b1; #1;
    chk("async_done", 64'(sn_done), 64'd0);
    done = 1'b0; wr_en = 1'b0;
    tick();
    rst = 1'b1;
    rdy_for_sn = 4'b1111;
    wait_offer("offer_timeout_post");
    ack = 1'b1; tick(); ack = 1'b0;
    chk("post_reset_grant", 64'(rdy_for_sn_ack), 64'h1);
    rdy_for_sn = '0;
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
